// File: rtl/bcd_seven_seg.sv
// ---------------------------------------------------------------------------
// bcd_seven_seg
//
// Registered BCD-to-seven-segment decoder for a 4-digit common-anode display.
// The anode enables are passed through unchanged so that the segment pattern
// and its digit select leave the block on the same clock edge.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst_n     in   1  synchronous reset, active-low
//   segSel    in   4  anode enables, active-low (0 = digit on)
//   a,b,c,d   in   1  code bits, a = MSB, d = LSB
//   anodeOut  out  4  registered copy of segSel
//   sevenOut  out  8  registered segments {dp,g,f,e,d,c,b,a}, active-low
//   bcdErr    out  1  registered flag, 1 when the code is not a BCD digit
//
// Configuration
//   BCD_SEVEN_SEG_HEX_DIGITS_EN  defined:   codes 10..15 show hex glyphs A..F
//                                undefined: codes 10..15 blank the digit
//   bcdErr is raised for codes 10..15 in both builds.
//
// Every output is a flop; there is no combinational path from any input to
// any output, and the latency is exactly one clock.
// ---------------------------------------------------------------------------
module bcd_seven_seg (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] segSel,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic [3:0] anodeOut,
    output logic [7:0] sevenOut,
    output logic       bcdErr
);

    // Segment patterns, active-low, bit order {dp,g,f,e,d,c,b,a}.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

`ifdef BCD_SEVEN_SEG_HEX_DIGITS_EN
    localparam logic [7:0] SEG_HEX_A = 8'h88;
    localparam logic [7:0] SEG_HEX_B = 8'h83;   // lower-case b
    localparam logic [7:0] SEG_HEX_C = 8'hC6;
    localparam logic [7:0] SEG_HEX_D = 8'hA1;   // lower-case d
    localparam logic [7:0] SEG_HEX_E = 8'h86;
    localparam logic [7:0] SEG_HEX_F = 8'h8E;
`else
    localparam logic [7:0] SEG_HEX_A = SEG_BLANK;
    localparam logic [7:0] SEG_HEX_B = SEG_BLANK;
    localparam logic [7:0] SEG_HEX_C = SEG_BLANK;
    localparam logic [7:0] SEG_HEX_D = SEG_BLANK;
    localparam logic [7:0] SEG_HEX_E = SEG_BLANK;
    localparam logic [7:0] SEG_HEX_F = SEG_BLANK;
`endif

    // The decimal point is never driven on this display.
    localparam logic [7:0] DP_OFF_MASK = 8'h80;

    logic [3:0] code;
    logic [7:0] segNext;
    logic       errNext;

    assign code = {a, b, c, d};

    // Decode. All 16 binary codes are listed explicitly, so the default arm
    // is reached only when a code bit is X/Z in a four-state simulation; it
    // then blanks the digit and flags the code as invalid.
    always_comb begin
        // NOTE: every variable assigned in this block gets a value before the
        // case, so no path leaves it unassigned and no latch is inferred.
        segNext = SEG_BLANK;
        errNext = 1'b1;
        case (code)
            4'd0:  begin segNext = SEG_0; errNext = 1'b0; end
            4'd1:  begin segNext = SEG_1; errNext = 1'b0; end
            4'd2:  begin segNext = SEG_2; errNext = 1'b0; end
            4'd3:  begin segNext = SEG_3; errNext = 1'b0; end
            4'd4:  begin segNext = SEG_4; errNext = 1'b0; end
            4'd5:  begin segNext = SEG_5; errNext = 1'b0; end
            4'd6:  begin segNext = SEG_6; errNext = 1'b0; end
            4'd7:  begin segNext = SEG_7; errNext = 1'b0; end
            4'd8:  begin segNext = SEG_8; errNext = 1'b0; end
            4'd9:  begin segNext = SEG_9; errNext = 1'b0; end
            4'd10: segNext = SEG_HEX_A;
            4'd11: segNext = SEG_HEX_B;
            4'd12: segNext = SEG_HEX_C;
            4'd13: segNext = SEG_HEX_D;
            4'd14: segNext = SEG_HEX_E;
            4'd15: segNext = SEG_HEX_F;
            default: begin
                segNext = SEG_BLANK;
                errNext = 1'b1;
            end
        endcase
    end

    // Output registers. Reset blanks the display: all anodes and segments
    // inactive (high), error flag clear.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples its inputs from before the edge, independent of order.
        if (!rst_n) begin
            anodeOut <= 4'hF;
            sevenOut <= SEG_BLANK;
            bcdErr   <= 1'b0;
        end else begin
            anodeOut <= segSel;
            sevenOut <= segNext | DP_OFF_MASK;
            bcdErr   <= errNext;
        end
    end

endmodule

// File: tb/tb_bcd_seven_seg.sv
// ---------------------------------------------------------------------------
// tb_bcd_seven_seg
//
// Directed and random stimulus for bcd_seven_seg. Each step drives the inputs
// just after a rising edge, pushes the expected registered result onto a
// queue, checks that the outputs still hold the previous result (no
// combinational path), then pops and compares after the next rising edge.
// ---------------------------------------------------------------------------
module tb_bcd_seven_seg;

    typedef struct packed {
        logic [3:0] anode;
        logic [7:0] seven;
        logic       err;
    } outT;

    logic       clk;
    logic       rst_n;
    logic [3:0] segSel;
    logic       a, b, c, d;
    logic [3:0] anodeOut;
    logic [7:0] sevenOut;
    logic       bcdErr;

    int  nChecks;
    int  nPass;
    outT expQ[$];
    outT lastExp;
    bit  lastValid;
    logic [7:0] segTable [16];

    bcd_seven_seg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .segSel   (segSel),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .anodeOut (anodeOut),
        .sevenOut (sevenOut),
        .bcdErr   (bcdErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic compareAll(input string tag, input outT exp);
        check({tag, ".anodeOut"}, {4'h0, anodeOut}, {4'h0, exp.anode});
        check({tag, ".sevenOut"}, sevenOut, exp.seven);
        check({tag, ".bcdErr"},   {7'h0, bcdErr}, {7'h0, exp.err});
    endtask

    // One clock of stimulus. Entered just after a rising edge.
    task automatic step(input string tag, input logic rstn, input logic [3:0] code,
                        input logic [3:0] sel);
        outT exp;
        rst_n        = rstn;
        {a, b, c, d} = code;
        segSel       = sel;
        if (rstn) exp = '{anode: sel, seven: segTable[code], err: (code > 4'd9)};
        else      exp = '{anode: 4'hF, seven: 8'hFF, err: 1'b0};
        expQ.push_back(exp);
        #1;
        if (lastValid) compareAll({tag, ".hold"}, lastExp);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            nChecks++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            exp = expQ.pop_front();
            compareAll(tag, exp);
            lastExp   = exp;
            lastValid = 1'b1;
        end
    endtask

    initial begin
        logic [7:0] decTable [10];
        logic [7:0] hexTable [6];
        decTable = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef BCD_SEVEN_SEG_HEX_DIGITS_EN
        hexTable = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
`else
        hexTable = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`endif
        for (int i = 0; i < 10; i++) segTable[i] = decTable[i];
        for (int i = 0; i < 6; i++)  segTable[10 + i] = hexTable[i];

        nChecks   = 0;
        nPass     = 0;
        lastValid = 1'b0;
        rst_n     = 1'b0;
        segSel    = 4'h0;
        {a, b, c, d} = 4'h0;
        @(posedge clk);
        #1;

        // Reset for two clocks with non-idle inputs.
        step("reset0", 1'b0, 4'd3, 4'h0);
        step("reset1", 1'b0, 4'd12, 4'h5);

        // Decimal sweep with all digits enabled.
        for (int i = 0; i < 10; i++) step($sformatf("dec%0d", i), 1'b1, 4'(i), 4'h0);

        // Invalid codes, descending.
        for (int i = 15; i >= 10; i--) step($sformatf("inv%0d", i), 1'b1, 4'(i), 4'h0);

        // Walking digit select with a fixed code.
        step("selE", 1'b1, 4'd2, 4'hE);
        step("selD", 1'b1, 4'd2, 4'hD);
        step("selB", 1'b1, 4'd2, 4'hB);
        step("sel7", 1'b1, 4'd2, 4'h7);

        // Mid-stream reset with code 8 steady.
        step("pre8",   1'b1, 4'd8, 4'h0);
        step("rst8",   1'b0, 4'd8, 4'h0);
        step("post8",  1'b1, 4'd8, 4'h0);
        step("post8b", 1'b1, 4'd8, 4'h0);

        // Random code and digit select.
        for (int i = 0; i < 1000; i++)
            step("rand", 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
